// File: rtl/stream_mux_rr.sv
// CH-to-1 stream multiplexer with a single registered output beat.
// Arbitration is round-robin or fixed-priority, with a per-channel force override.
module stream_mux_rr #(
  parameter int N  = 32,
  parameter int CH = 4,
  parameter int RR = 1,
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*N-1:0]   in_data,
  output logic [CH-1:0]     in_ready,
  input  logic              force_en,
  input  logic [SELW-1:0]   force_sel,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  // state   | meaning
  // S_EMPTY | output register holds no beat
  // S_FULL  | output register holds a beat waiting for out_ready
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ch_q;
  logic [N-1:0]    data_q, cand_data;
  logic [SELW-1:0] cand, hi_sel, lo_sel;
  logic            cand_vld, hi_vld, lo_vld;
  logic            space, load;

  // hi_* is the first requester at or above ptr, lo_* the lowest requester overall;
  // together they give the wrapped round-robin search.
  always_comb begin
    hi_vld   = 1'b0;
    hi_sel   = '0;
    lo_vld   = 1'b0;
    lo_sel   = '0;
    cand_vld = 1'b0;
    cand     = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_vld = 1'b1;
        lo_sel = SELW'(i);
        if (RR != 0 && SELW'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_sel = SELW'(i);
        end
      end
    end
    if (force_en) begin
      // out-of-range force_sel matches no channel, so it never grants
      for (int i = 0; i < CH; i++) begin
        if (force_sel == SELW'(i) && in_valid[i]) begin
          cand_vld = 1'b1;
          cand     = SELW'(i);
        end
      end
    end else begin
      cand_vld = lo_vld;
      cand     = hi_vld ? hi_sel : lo_sel;
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (cand == SELW'(i)) cand_data = in_data[i*N +: N];
    end
  end

  assign space = (state_q == S_EMPTY) || out_ready;
  assign load  = cand_vld && space && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CH; i++) begin
      in_ready[i] = load && (cand == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (!load && out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= '0;
    end else if (load) begin
      data_q <= cand_data;
      ch_q   <= cand;
      if (RR != 0) ptr_q <= (cand == SELW'(CH - 1)) ? '0 : cand + SELW'(1);
    end
  end

  assign out_data = data_q;
  assign out_ch   = ch_q;

endmodule
